// File: rtl/irq_arbiter.sv
// irq_arbiter: synchronises external interrupt lines, latches rising edges
// into a pending register and offers the highest-priority enabled request
// to the pipeline controller, keeping one external interrupt in flight.
module irq_arbiter #(
    parameter int N_SRC    = 8,
    parameter int IRQ_ID_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_SRC-1:0]    irq_src_i,
    input  logic [N_SRC-1:0]    irq_enable_i,
    output logic [IRQ_ID_W-1:0] irq_req_addr_o,
    input  logic                irq_ack_i,
    input  logic                irq_complete_i,
    output logic [N_SRC-1:0]    irq_pending_o,
    output logic                irq_in_service_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t                state_q;
    logic [N_SRC-1:0]      s1_q, s2_q, s3_q;
    logic [N_SRC-1:0]      pending_q, pending_d;
    logic [N_SRC-1:0]      rise, cand, lock_mask, clr_mask;
    logic [IRQ_ID_W-1:0]   lock_id_q, req_addr_q, win_id;
    logic                  in_service_q;
    logic                  win_vld, ack_take, withdraw;

    // Three-flop chain: two for metastability, the third for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= irq_src_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;
    assign cand = pending_q & irq_enable_i;

    // Lowest set candidate index wins; scanning downward leaves it last.
    always_comb begin
        win_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) win_id = IRQ_ID_W'(i + 1);
        end
    end

    assign win_vld = |cand;

    // One-hot view of the locked ID, used for the clear and withdraw checks.
    always_comb begin
        lock_mask = '0;
        for (int i = 0; i < N_SRC; i++) begin
            lock_mask[i] = (lock_id_q == IRQ_ID_W'(i + 1));
        end
    end

    assign ack_take = (state_q == ST_REQ) && irq_ack_i;
    // Ack has priority over withdrawal in the same REQ cycle.
    assign withdraw = (state_q == ST_REQ) && !irq_ack_i &&
                      !(|(lock_mask & irq_enable_i & pending_q));
    assign clr_mask = ack_take ? lock_mask : '0;
    // A new edge on the bit being acknowledged keeps it pending (set wins).
    assign pending_d = (pending_q & ~clr_mask) | rise;

    // Pending register: edges latch regardless of the enable mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Request/acknowledge/complete handshake with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lock_id_q    <= '0;
            req_addr_q   <= '0;
            in_service_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_vld) begin
                        lock_id_q  <= win_id;
                        req_addr_q <= win_id;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack_take) begin
                        req_addr_q   <= '0;
                        in_service_q <= 1'b1;
                        state_q      <= ST_SERVICE;
                    end else if (withdraw) begin
                        req_addr_q <= '0;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (irq_complete_i) begin
                        in_service_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    req_addr_q   <= '0;
                    in_service_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign irq_req_addr_o   = req_addr_q;
    assign irq_pending_o    = pending_q;
    assign irq_in_service_o = in_service_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter with a cycle-level reference model.
module tb_irq_arbiter;
    localparam int N = 8;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] src = '0;
    logic [N-1:0] en = '1;
    logic         ack = 1'b0;
    logic         cmp = 1'b0;
    logic [W-1:0] addr;
    logic [N-1:0] pend;
    logic         svc;

    int n_vec = 0;
    int n_bad = 0;
    bit running = 1'b0;

    irq_arbiter #(.N_SRC(N), .IRQ_ID_W(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .irq_src_i        (src),
        .irq_enable_i     (en),
        .irq_req_addr_o   (addr),
        .irq_ack_i        (ack),
        .irq_complete_i   (cmp),
        .irq_pending_o    (pend),
        .irq_in_service_o (svc)
    );

    always #5 clk = ~clk;

    // Reference model: raw line samples from the last edges, pending set,
    // offered ID (0 = none) and in-service flag.
    logic [N-1:0] smp0 = '0, smp1 = '0, smp2 = '0;
    logic [N-1:0] m_pend = '0, n_pend, m_rise, m_cand;
    int           m_offer = 0, n_offer;
    bit           m_svc = 1'b0, n_svc;

    function automatic int lowest_id(input logic [N-1:0] c);
        for (int i = 0; i < N; i++) if (c[i]) return i + 1;
        return 0;
    endfunction

    always_comb begin
        // An edge is seen when the line was sampled high two edges ago and
        // low three edges ago.
        m_rise  = smp1 & ~smp2;
        m_cand  = m_pend & en;
        n_pend  = m_pend;
        n_offer = m_offer;
        n_svc   = m_svc;
        if (m_svc) begin
            if (cmp) n_svc = 1'b0;
        end else if (m_offer != 0) begin
            if (ack) begin
                n_pend[m_offer-1] = 1'b0;
                n_offer = 0;
                n_svc = 1'b1;
            end else if (!(en[m_offer-1] && m_pend[m_offer-1])) begin
                n_offer = 0;
            end
        end else if (m_cand != '0) begin
            n_offer = lowest_id(m_cand);
        end
        n_pend = n_pend | m_rise;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp0 <= '0; smp1 <= '0; smp2 <= '0;
            m_pend <= '0; m_offer <= 0; m_svc <= 1'b0;
        end else begin
            smp0 <= src; smp1 <= smp0; smp2 <= smp1;
            m_pend <= n_pend; m_offer <= n_offer; m_svc <= n_svc;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every falling edge: DUT outputs against the model.
    always @(negedge clk) begin
        if (running) begin
            chk("model_addr", int'(addr), m_offer);
            chk("model_in_service", int'(svc), int'(m_svc));
            chk("model_pending", int'(pend), int'(m_pend));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack();
        ack = 1'b1; tick(1); ack = 1'b0;
    endtask

    task automatic pulse_cmp();
        cmp = 1'b1; tick(1); cmp = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        running = 1'b1;
        tick(2);
        chk("reset_addr", int'(addr), 0);
        chk("reset_in_service", int'(svc), 0);
        chk("reset_pending", int'(pend), 0);
        rst_n = 1'b1;
        tick(2);

        // Single source 2: pending two edges after the sampling edge, ID one later.
        src = 8'h04;
        tick(3);
        chk("single_pending", int'(pend), 8'h04);
        chk("single_addr_early", int'(addr), 0);
        tick(1);
        chk("single_addr", int'(addr), 3);
        tick(1);
        pulse_ack();
        chk("single_ack_addr", int'(addr), 0);
        chk("single_ack_svc", int'(svc), 1);
        chk("single_ack_pending", int'(pend), 0);
        tick(3);
        pulse_cmp();
        chk("single_cmp_svc", int'(svc), 0);
        tick(3);
        chk("held_high_pending", int'(pend), 0);
        chk("held_high_addr", int'(addr), 0);
        src = '0;
        tick(3);

        // Priority and lock: sources 5 and 1 together, then 0 during REQ.
        src = 8'h22;
        tick(4);
        chk("prio_addr", int'(addr), 2);
        src = 8'h23;
        tick(3);
        chk("lock_addr", int'(addr), 2);
        chk("lock_pending", int'(pend), 8'h23);
        pulse_ack();
        chk("prio_ack_pending", int'(pend), 8'h21);
        pulse_cmp();
        chk("prio_gap_addr", int'(addr), 0);
        tick(1);
        chk("prio_next_addr", int'(addr), 1);
        pulse_ack();
        chk("prio_next_pending", int'(pend), 8'h20);
        pulse_cmp();
        tick(1);
        chk("prio_last_addr", int'(addr), 6);
        pulse_ack();
        pulse_cmp();
        src = '0;
        tick(3);

        // Masking: source 3 pending while disabled.
        en = 8'hF7;
        src = 8'h08;
        tick(5);
        chk("mask_addr", int'(addr), 0);
        chk("mask_pending", int'(pend), 8'h08);
        en = 8'hFF;
        tick(1);
        chk("mask_release_addr", int'(addr), 4);

        // Withdraw: drop the enable while requesting.
        en = 8'hF7;
        tick(1);
        chk("withdraw_addr", int'(addr), 0);
        chk("withdraw_pending", int'(pend), 8'h08);
        tick(2);
        chk("withdraw_idle_addr", int'(addr), 0);
        en = 8'hFF;
        tick(1);
        chk("withdraw_reissue", int'(addr), 4);
        pulse_ack();
        pulse_cmp();
        src = '0;
        tick(3);

        // Set/clear collision on source 1.
        src = 8'h02;
        tick(4);
        chk("coll_addr", int'(addr), 2);
        src = '0;
        tick(2);
        src = 8'h02;
        tick(2);
        pulse_ack();
        chk("coll_pending", int'(pend), 8'h02);
        chk("coll_svc", int'(svc), 1);
        pulse_cmp();
        tick(1);
        chk("coll_reissue", int'(addr), 2);
        pulse_ack();
        pulse_cmp();
        src = '0;
        tick(3);

        // Asynchronous reset in SERVICE, then spurious ack/complete.
        src = 8'h80;
        tick(4);
        chk("rst_pre_addr", int'(addr), 8);
        pulse_ack();
        chk("rst_pre_svc", int'(svc), 1);
        #2;
        src = '0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_addr", int'(addr), 0);
        chk("async_rst_svc", int'(svc), 0);
        chk("async_rst_pending", int'(pend), 0);
        tick(2);
        rst_n = 1'b1;
        ack = 1'b1;
        cmp = 1'b1;
        tick(1);
        ack = 1'b0;
        cmp = 1'b0;
        tick(3);
        chk("spurious_addr", int'(addr), 0);
        chk("spurious_svc", int'(svc), 0);
        chk("spurious_pending", int'(pend), 0);

        running = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
